// File: rtl/reg_alu_sequencer_if.sv
// Sequencer <-> instruction ROM / reg_file_alu datapath bus.
// Latency: n/a (signal bundle only); imem_rdata arrives one cycle after imem_addr.
// Backpressure: none; the ROM and datapath always accept.
//   master: driven by the sequencer (address, decoded controls), samples rdata/zero.
//   slave : ROM/datapath side, returns imem_rdata and alu_zero.
interface reg_alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            alu_zero;
    logic [3:0]      RA1;
    logic [3:0]      RA2;
    logic [3:0]      WA;
    logic [7:0]      immediate;
    logic [1:0]      ALUControl;
    logic            ALUSrc;
    logic            write_enable;

    modport master (
        output imem_addr, RA1, RA2, WA, immediate, ALUControl, ALUSrc, write_enable,
        input  imem_rdata, alu_zero
    );

    modport slave (
        input  imem_addr, RA1, RA2, WA, immediate, ALUControl, ALUSrc, write_enable,
        output imem_rdata, alu_zero
    );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Fetch/decode/execute sequencer driving the reg_file_alu datapath from a sync ROM.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC); controls valid in EXEC.
// Backpressure: none; start is only honoured while idle or halted.
//   Ports: clk, rst_n (async, active low), start, bus (master side of the
//   ROM/datapath interface), busy, done, retired (instructions completed).
module reg_alu_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    reg_alu_sequencer_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_BZ   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [3:0]       op;
    logic             is_alu;
    logic [31:0]      imm_sext;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  pc_inc;

    assign op       = ir_q[15:12];
    assign imm_sext = 32'(signed'(ir_q[7:0]));
    // Branch and increment both rely on natural PC_W-bit wrap.
    assign br_target = pc_q + imm_sext[PC_W-1:0];
    assign pc_inc    = pc_q + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Sequencing and program-counter update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = bus.imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    if (retired_q != '1) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    case (op)
                        OP_BZ:   pc_d = bus.alu_zero ? br_target : pc_inc;
                        OP_JMP:  pc_d = PC_W'(ir_q[7:0]);
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode is purely from IR so the controls stay stable between
    // instructions; only the write strobe is qualified by EXEC.
    always_comb begin
        bus.RA1        = '0;
        bus.RA2        = '0;
        bus.WA         = '0;
        bus.immediate  = '0;
        bus.ALUControl = '0;
        bus.ALUSrc     = 1'b0;
        is_alu         = 1'b0;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                is_alu         = 1'b1;
                bus.WA         = ir_q[11:8];
                bus.RA1        = ir_q[7:4];
                bus.RA2        = ir_q[3:0];
                bus.ALUControl = op[1:0];
            end
            4'h4, 4'h5, 4'h6, 4'h7: begin
                is_alu         = 1'b1;
                bus.WA         = ir_q[11:8];
                bus.RA1        = ir_q[11:8];
                bus.immediate  = ir_q[7:0];
                bus.ALUSrc     = 1'b1;
                bus.ALUControl = op[1:0];
            end
            OP_BZ: begin
                // rd OR 0 lets the datapath raise Zero exactly when rd == 0.
                bus.RA1        = ir_q[11:8];
                bus.ALUSrc     = 1'b1;
                bus.ALUControl = 2'b11;
            end
            default: ;
        endcase
    end

    assign bus.write_enable = is_alu && (state_q == S_EXEC);
    assign bus.imem_addr    = pc_q;
    assign busy             = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign done             = (state_q == S_HALT);
    assign retired          = retired_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Self-checking bench for reg_alu_sequencer: directed scenarios plus random
// programs compared against an instruction-level reference model.
// Drives a synchronous ROM and a per-address Zero table for the datapath side.
module tb_reg_alu_sequencer;
    localparam int PC_W  = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic       we;
        logic [3:0] wa;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [7:0] imm;
        logic [1:0] ctl;
        logic       src;
    } dec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] retired;

    logic [15:0] rom  [256];
    logic        ztab [256];

    int vectors     = 0;
    int miscompares = 0;

    reg_alu_sequencer_if #(.PC_W(PC_W)) bus ();

    reg_alu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .retired (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];
    assign bus.alu_zero = ztab[bus.imem_addr];

    // ---------------- reference model / observation ----------------
    function automatic dec_t model_dec(input logic [15:0] ins);
        dec_t d;
        int   op;
        op = int'(ins[15:12]);
        d  = '0;
        if (op <= 3) begin
            d.we  = 1'b1;
            d.wa  = ins[11:8];
            d.ra1 = ins[7:4];
            d.ra2 = ins[3:0];
            d.ctl = 2'(op);
        end else if (op <= 7) begin
            d.we  = 1'b1;
            d.wa  = ins[11:8];
            d.ra1 = ins[11:8];
            d.imm = ins[7:0];
            d.src = 1'b1;
            d.ctl = 2'(op - 4);
        end else if (op == 8) begin
            d.ra1 = ins[11:8];
            d.src = 1'b1;
            d.ctl = 2'd3;
        end
        return d;
    endfunction

    function automatic int model_next_pc(input int pc, input logic [15:0] ins, input logic zero);
        int imm;
        imm = int'(ins[7:0]);
        if (ins[15:12] == 4'h8) begin
            if (zero) return (pc + ((imm >= 128) ? imm - 256 : imm) + 256) % 256;
            return (pc + 1) % 256;
        end
        if (ins[15:12] == 4'h9) return imm;
        return (pc + 1) % 256;
    endfunction

    function automatic dec_t observed();
        return {bus.write_enable, bus.WA, bus.RA1, bus.RA2, bus.immediate, bus.ALUControl, bus.ALUSrc};
    endfunction

    function automatic logic [49:0] all_outs();
        return {bus.imem_addr, bus.RA1, bus.RA2, bus.WA, bus.immediate, bus.ALUControl,
                bus.ALUSrc, bus.write_enable, busy, done, retired};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_mem();
        for (int a = 0; a < 256; a++) begin
            rom[a]  = 16'hF000;
            ztab[a] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge inside FETCH of instruction 0.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #13;
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_async outs=%h exp=0", all_outs());
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_held outs=%h exp=0", all_outs());
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_idle outs=%h exp=0", all_outs());
        end
    endtask

    task automatic test_addi();
        dec_t exp_d;
        clear_mem();
        rom[0] = 16'h4105;
        rom[1] = 16'hF000;
        apply_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        exp_d = '{1'b1, 4'd1, 4'd1, 4'd0, 8'd5, 2'd0, 1'b1};
        vectors++;
        if (observed() !== exp_d) begin
            miscompares++;
            $display("FAIL addi_exec got=%h exp=%h", observed(), exp_d);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL addi_busy got=%b exp=1", busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.write_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL addi_we_one_cycle got=%b exp=0", bus.write_enable);
        end
        for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clk);
        vectors++;
        if ({done, busy, retired} !== {1'b1, 1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL addi_halt done=%b busy=%b retired=%0d exp 1/0/1", done, busy, retired);
        end
    endtask

    task automatic test_sub();
        dec_t exp_d;
        clear_mem();
        rom[0] = 16'h1211;
        apply_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        exp_d = '{1'b1, 4'd2, 4'd1, 4'd1, 8'd0, 2'd1, 1'b0};
        vectors++;
        if (observed() !== exp_d) begin
            miscompares++;
            $display("FAIL sub_exec got=%h exp=%h", observed(), exp_d);
        end
    endtask

    task automatic test_bz();
        dec_t exp_d;
        for (int z = 1; z >= 0; z--) begin
            clear_mem();
            rom[0]  = 16'h8003;
            ztab[0] = 1'(z);
            apply_reset();
            pulse_start();
            repeat (2) @(negedge clk);
            exp_d = '{1'b0, 4'd0, 4'd0, 4'd0, 8'd0, 2'd3, 1'b1};
            vectors++;
            if (observed() !== exp_d) begin
                miscompares++;
                $display("FAIL bz_decode z=%0d got=%h exp=%h", z, observed(), exp_d);
            end
            @(negedge clk);
            vectors++;
            if (bus.imem_addr !== ((z == 1) ? 8'd3 : 8'd1)) begin
                miscompares++;
                $display("FAIL bz_target z=%0d got=%0d exp=%0d", z, bus.imem_addr, (z == 1) ? 3 : 1);
            end
        end
        clear_mem();
        rom[0]  = 16'h9005;
        rom[5]  = 16'h80FF;
        ztab[5] = 1'b1;
        apply_reset();
        pulse_start();
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.imem_addr !== 8'd5) begin
            miscompares++;
            $display("FAIL bz_back_pc got=%0d exp=5", bus.imem_addr);
        end
        @(negedge clk);
        vectors++;
        if (bus.imem_addr !== 8'd4) begin
            miscompares++;
            $display("FAIL bz_back_target got=%0d exp=4", bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        rom[0]   = 16'h90FF;
        rom[255] = 16'h0000;
        apply_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.imem_addr, bus.write_enable} !== {8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL jmp_exec addr=%0d we=%b exp 0/0", bus.imem_addr, bus.write_enable);
        end
        @(negedge clk);
        vectors++;
        if (bus.imem_addr !== 8'd255) begin
            miscompares++;
            $display("FAIL jmp_target got=%0d exp=255", bus.imem_addr);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.imem_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL pc_wrap got=%0d exp=0", bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        rom[0] = 16'h4105;
        apply_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_we got=%b exp=1", bus.write_enable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outs got=%h exp=0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({busy, done, retired, bus.imem_addr} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_idle busy=%b done=%b retired=%0d addr=%0d exp all 0",
                     busy, done, retired, bus.imem_addr);
        end
    endtask

    task automatic test_start_ignored();
        clear_mem();
        rom[0] = 16'h4105;
        rom[1] = 16'h4206;
        rom[2] = 16'hF000;
        apply_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.imem_addr !== 8'd1) begin
            miscompares++;
            $display("FAIL busy_start_fetch got=%0d exp=1", bus.imem_addr);
        end
        repeat (2) @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({bus.imem_addr, bus.WA, retired} !== {8'd1, 4'd2, 16'd1}) begin
            miscompares++;
            $display("FAIL busy_start_exec addr=%0d wa=%0d retired=%0d exp 1/2/1",
                     bus.imem_addr, bus.WA, retired);
        end
        for (int i = 0; i < 12 && done !== 1'b1; i++) @(negedge clk);
        vectors++;
        if ({done, busy, retired} !== {1'b1, 1'b0, 16'd2}) begin
            miscompares++;
            $display("FAIL busy_start_halt done=%b busy=%b retired=%0d exp 1/0/2", done, busy, retired);
        end
    endtask

    task automatic test_random();
        int          pc;
        logic [15:0] ins;
        dec_t        exp_d;
        for (int prog = 0; prog < 25; prog++) begin
            for (int a = 0; a < 256; a++) begin
                rom[a]  = 16'($urandom);
                ztab[a] = 1'($urandom);
                if ($urandom_range(0, 9) == 0) rom[a][15:12] = 4'hF;
            end
            apply_reset();
            pulse_start();
            repeat (2) @(negedge clk);
            pc = 0;
            for (int step = 0; step < 40; step++) begin
                ins   = rom[pc];
                exp_d = model_dec(ins);
                vectors++;
                if ({bus.imem_addr, busy, retired} !== {8'(pc), 1'b1, 16'(step)}) begin
                    miscompares++;
                    $display("FAIL rand_state prog=%0d step=%0d addr=%0d busy=%b retired=%0d exp pc=%0d busy=1 retired=%0d",
                             prog, step, bus.imem_addr, busy, retired, pc, step);
                end
                vectors++;
                if (observed() !== exp_d) begin
                    miscompares++;
                    $display("FAIL rand_decode prog=%0d step=%0d ins=%h got=%h exp=%h",
                             prog, step, ins, observed(), exp_d);
                end
                if (ins[15:12] == 4'hF) begin
                    @(negedge clk);
                    vectors++;
                    if ({done, busy, retired} !== {1'b1, 1'b0, 16'(step)}) begin
                        miscompares++;
                        $display("FAIL rand_halt prog=%0d done=%b busy=%b retired=%0d exp 1/0/%0d",
                                 prog, done, busy, retired, step);
                    end
                    break;
                end
                pc = model_next_pc(pc, ins, ztab[pc]);
                repeat (3) @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();
        test_reset();
        test_addi();
        test_sub();
        test_bz();
        test_wrap();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
